// File: rtl/spi_master_xfer.sv
// SPI master transfer engine: accepts one word per valid/ready handshake, shifts it out
// with per-transfer CPOL/CPHA/bit-order/divider/select, and returns the received word.
module spi_master_xfer #(
    parameter int MAX_LEN = 32,
    parameter int SS_W    = 4,
    parameter int DIV_W   = 8
) (
    input  logic                      pclk,
    input  logic                      p_reset,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    input  logic [MAX_LEN-1:0]        tx_data,
    input  logic [$clog2(MAX_LEN):0]  cfg_len,
    input  logic [DIV_W-1:0]          cfg_div,
    input  logic                      cfg_cpol,
    input  logic                      cfg_cpha,
    input  logic                      cfg_lsb,
    input  logic [SS_W-1:0]           cfg_ss,
    output logic                      rx_valid,
    output logic [MAX_LEN-1:0]        rx_data,
    output logic                      busy,
    input  logic                      mi,
    output logic                      sclk_out,
    output logic                      n_sclk_en,
    output logic                      mo,
    output logic                      n_mo_en,
    output logic [SS_W-1:0]           n_ss_out,
    output logic                      n_ss_en
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    localparam int EW    = LEN_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

    state_t             state;
    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   div_q;
    logic [EW-1:0]      edge_cnt;
    logic [LEN_W-1:0]   len_q;
    logic               cpha_q;
    logic               lsb_q;
    logic [MAX_LEN-1:0] tx_sh;
    logic [MAX_LEN-1:0] rx_sh;

    logic [LEN_W-1:0]   len_eff;
    logic [MAX_LEN-1:0] tx_aligned;
    logic               lead_edge;
    logic               last_edge;

    // MSB-first words are pre-aligned so the outgoing bit always sits at MAX_LEN-1.
    always_comb begin
        len_eff = cfg_len;
        if (cfg_len == '0 || cfg_len > LEN_W'(MAX_LEN))
            len_eff = LEN_W'(MAX_LEN);
        tx_aligned = cfg_lsb ? tx_data : (tx_data << (LEN_W'(MAX_LEN) - len_eff));
        lead_edge  = ~edge_cnt[0];
        last_edge  = (edge_cnt == ({len_q, 1'b0} - EW'(1)));
    end

    always_ff @(posedge pclk) begin
        if (p_reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            div_q     <= '0;
            edge_cnt  <= '0;
            len_q     <= '0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            tx_ready  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            busy      <= 1'b0;
            sclk_out  <= 1'b0;
            n_sclk_en <= 1'b1;
            mo        <= 1'b0;
            n_mo_en   <= 1'b1;
            n_ss_out  <= '1;
            n_ss_en   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    sclk_out <= cfg_cpol;
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        state     <= S_SETUP;
                        tx_ready  <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= cfg_div;
                        div_q     <= cfg_div;
                        len_q     <= len_eff;
                        cpha_q    <= cfg_cpha;
                        lsb_q     <= cfg_lsb;
                        tx_sh     <= tx_aligned;
                        rx_sh     <= '0;
                        edge_cnt  <= '0;
                        mo        <= cfg_lsb ? tx_aligned[0] : tx_aligned[MAX_LEN-1];
                        n_ss_out  <= ~cfg_ss;
                        n_ss_en   <= 1'b0;
                        n_sclk_en <= 1'b0;
                        n_mo_en   <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        cnt   <= div_q;
                        state <= S_SHIFT;
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (cnt == '0) begin
                        cnt      <= div_q;
                        sclk_out <= ~sclk_out;
                        edge_cnt <= edge_cnt + EW'(1);
                        // Sample edge is the leading one for CPHA=0, trailing for CPHA=1.
                        if (lead_edge ^ cpha_q) begin
                            rx_sh <= lsb_q ? {mi, rx_sh[MAX_LEN-1:1]} : {rx_sh[MAX_LEN-2:0], mi};
                        end else if (!last_edge && !(cpha_q && edge_cnt == '0)) begin
                            tx_sh <= lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
                            mo    <= lsb_q ? tx_sh[1] : tx_sh[MAX_LEN-2];
                        end
                        if (last_edge)
                            state <= S_HOLD;
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        state     <= S_DONE;
                        rx_valid  <= 1'b1;
                        // LSB-first bits collect at the top; slide them down to right-justify.
                        rx_data   <= lsb_q ? (rx_sh >> (LEN_W'(MAX_LEN) - len_q)) : rx_sh;
                        n_ss_out  <= '1;
                        n_ss_en   <= 1'b1;
                        n_sclk_en <= 1'b1;
                        n_mo_en   <= 1'b1;
                        mo        <= 1'b0;
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    rx_valid <= 1'b0;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_xfer.sv
// Directed bench for spi_master_xfer: loopback and slave-model transfers with
// hand-computed latency, data, edge counts and select levels.
module tb_spi_master_xfer;
    localparam int MAX_LEN = 32;
    localparam int SS_W    = 4;
    localparam int DIV_W   = 8;

    logic                pclk = 1'b0;
    logic                p_reset = 1'b1;
    logic                tx_valid = 1'b0;
    logic                tx_ready;
    logic [MAX_LEN-1:0]  tx_data = '0;
    logic [5:0]          cfg_len = 6'd8;
    logic [DIV_W-1:0]    cfg_div = '0;
    logic                cfg_cpol = 1'b0;
    logic                cfg_cpha = 1'b0;
    logic                cfg_lsb = 1'b0;
    logic [SS_W-1:0]     cfg_ss = '0;
    logic                rx_valid;
    logic [MAX_LEN-1:0]  rx_data;
    logic                busy;
    logic                mi;
    logic                sclk_out;
    logic                n_sclk_en;
    logic                mo;
    logic                n_mo_en;
    logic [SS_W-1:0]     n_ss_out;
    logic                n_ss_en;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int edges = 0;
    int rises = 0;
    int trl = 0;
    int rxv_cnt = 0;
    int trl_base = 0;
    int t_acc = 0;
    int t_rx = 0;
    int lat = 0;
    logic [31:0] rxd;
    logic [3:0]  ss_seen;
    logic        rdy_seen;
    logic        busy_at_done;
    logic [31:0] mo_hist = '0;
    logic        use_slave = 1'b0;
    logic [31:0] slave_word = '0;

    spi_master_xfer #(.MAX_LEN(MAX_LEN), .SS_W(SS_W), .DIV_W(DIV_W)) dut (
        .pclk(pclk), .p_reset(p_reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .cfg_len(cfg_len), .cfg_div(cfg_div), .cfg_cpol(cfg_cpol),
        .cfg_cpha(cfg_cpha), .cfg_lsb(cfg_lsb), .cfg_ss(cfg_ss), .rx_valid(rx_valid),
        .rx_data(rx_data), .busy(busy), .mi(mi), .sclk_out(sclk_out), .n_sclk_en(n_sclk_en),
        .mo(mo), .n_mo_en(n_mo_en), .n_ss_out(n_ss_out), .n_ss_en(n_ss_en)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc++;
    always @(posedge pclk) if (rx_valid === 1'b1) rxv_cnt++;

    // Slave model: shifts its next bit out after each trailing sclk edge.
    always @(sclk_out) begin
        edges++;
        if (sclk_out === cfg_cpol) trl++;
    end
    always @(posedge sclk_out) begin
        rises++;
        mo_hist = {mo_hist[30:0], mo};
    end
    assign mi = use_slave ? slave_word[(trl - trl_base) & 31] : mo;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [31:0] d, input logic [5:0] len, input logic [7:0] div,
                           input logic cpol, input logic cpha, input logic lsb, input logic [3:0] ss);
        tx_data  = d;
        cfg_len  = len;
        cfg_div  = div;
        cfg_cpol = cpol;
        cfg_cpha = cpha;
        cfg_lsb  = lsb;
        cfg_ss   = ss;
    endtask

    // Called at a negedge; returns at the negedge of the cycle after accept.
    task automatic start_req(input logic hold);
        int n = 0;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 2000) begin
            @(negedge pclk);
            n++;
        end
        chk("accept_timeout", 32'(n < 2000), 32'd1);
        t_acc = cyc;
        @(negedge pclk);
        tx_valid = hold;
    endtask

    task automatic wait_done();
        int n = 0;
        ss_seen  = '0;
        rdy_seen = 1'b0;
        while (rx_valid !== 1'b1 && n < 20000) begin
            ss_seen  = ss_seen | ~n_ss_out;
            rdy_seen = rdy_seen | tx_ready;
            @(negedge pclk);
            n++;
        end
        chk("done_timeout", 32'(n < 20000), 32'd1);
        t_rx = cyc;
        lat = t_rx - t_acc;
        rxd = rx_data;
        busy_at_done = busy;
    endtask

    initial begin
        int r0;
        int e0;
        int t_rx1;
        int n;
        repeat (3) @(negedge pclk);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", rx_data, 32'd0);
        chk("rst_sclk", 32'(sclk_out), 32'd0);
        chk("rst_mo", 32'(mo), 32'd0);
        chk("rst_enables", {29'd0, n_sclk_en, n_mo_en, n_ss_en}, 32'h7);
        chk("rst_n_ss_out", 32'(n_ss_out), 32'hF);
        p_reset = 1'b0;
        @(negedge pclk);
        chk("rst_release_ready", 32'(tx_ready), 32'd1);

        // Mode 0, MSB first, loopback
        set_cfg(32'hA5, 6'd8, 8'd0, 1'b0, 1'b0, 1'b0, 4'b0001);
        @(negedge pclk);
        r0 = rises;
        start_req(1'b0);
        chk("t1_ss_out", 32'(n_ss_out), 32'hE);
        chk("t1_enables", {29'd0, n_sclk_en, n_mo_en, n_ss_en}, 32'h0);
        wait_done();
        chk("t1_latency", lat, 32'd19);
        chk("t1_rx_data", rxd, 32'hA5);
        chk("t1_rises", rises - r0, 32'd8);
        chk("t1_mo_bits", {24'd0, mo_hist[7:0]}, 32'hA5);
        chk("t1_busy_at_done", 32'(busy_at_done), 32'd1);
        chk("t1_ready_low", 32'(rdy_seen), 32'd0);
        @(negedge pclk);
        chk("t1_rx_valid_pulse", 32'(rx_valid), 32'd0);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_ss_released", 32'(n_ss_out), 32'hF);

        // Mode 3, LSB first, slave model returns 0xBEEF
        set_cfg(32'h1234, 6'd16, 8'd3, 1'b1, 1'b1, 1'b1, 4'b0010);
        repeat (2) @(negedge pclk);
        chk("t2_idle_sclk", 32'(sclk_out), 32'd1);
        slave_word = 32'hBEEF;
        trl_base = trl;
        use_slave = 1'b1;
        start_req(1'b0);
        wait_done();
        use_slave = 1'b0;
        chk("t2_latency", lat, 32'd137);
        chk("t2_rx_data", rxd, 32'h0000BEEF);

        // len=0 means MAX_LEN
        set_cfg(32'hDEADBEEF, 6'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'b0001);
        repeat (2) @(negedge pclk);
        r0 = rises;
        start_req(1'b0);
        wait_done();
        chk("t3_rises", rises - r0, 32'd32);
        chk("t3_rx_data", rxd, 32'hDEADBEEF);
        chk("t3_latency", lat, 32'd67);

        // len above MAX_LEN clamps; LSB first, CPHA=1
        set_cfg(32'hCAFEF00D, 6'd40, 8'd0, 1'b0, 1'b1, 1'b1, 4'b0100);
        @(negedge pclk);
        start_req(1'b0);
        wait_done();
        chk("t4_rx_data", rxd, 32'hCAFEF00D);
        chk("t4_latency", lat, 32'd67);

        // Back-to-back, config changed mid-transfer only affects the second word
        set_cfg(32'h11, 6'd8, 8'd0, 1'b0, 1'b0, 1'b0, 4'b0001);
        @(negedge pclk);
        start_req(1'b1);
        tx_data = 32'h22;
        cfg_div = 8'd1;
        cfg_lsb = 1'b1;
        wait_done();
        chk("t5a_latency", lat, 32'd19);
        chk("t5a_rx_data", rxd, 32'h11);
        chk("t5a_ready_low", 32'(rdy_seen), 32'd0);
        t_rx1 = t_rx;
        start_req(1'b0);
        chk("t5_b2b_accept", t_acc, t_rx1 + 1);
        wait_done();
        chk("t5b_latency", lat, 32'd37);
        chk("t5b_rx_data", rxd, 32'h22);
        chk("t5b_ready_low", 32'(rdy_seen), 32'd0);

        // Reset at the 5th sclk edge aborts the transfer
        set_cfg(32'h3C, 6'd8, 8'd1, 1'b0, 1'b0, 1'b0, 4'b0001);
        @(negedge pclk);
        e0 = edges;
        start_req(1'b0);
        n = 0;
        while (edges - e0 < 5 && n < 200) begin
            @(negedge pclk);
            n++;
        end
        chk("t6_edge_timeout", 32'(n < 200), 32'd1);
        r0 = rxv_cnt;
        p_reset = 1'b1;
        @(negedge pclk);
        chk("t6_enables", {29'd0, n_sclk_en, n_mo_en, n_ss_en}, 32'h7);
        chk("t6_n_ss_out", 32'(n_ss_out), 32'hF);
        chk("t6_sclk", 32'(sclk_out), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        p_reset = 1'b0;
        repeat (40) @(negedge pclk);
        chk("t6_no_rx_valid", rxv_cnt - r0, 32'd0);
        set_cfg(32'h5A, 6'd8, 8'd1, 1'b0, 1'b0, 1'b0, 4'b0001);
        start_req(1'b0);
        wait_done();
        chk("t6_after_rx_data", rxd, 32'h5A);
        chk("t6_after_latency", lat, 32'd37);

        // No select, single bit
        set_cfg(32'h1, 6'd1, 8'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
        @(negedge pclk);
        e0 = edges;
        r0 = rxv_cnt;
        start_req(1'b0);
        wait_done();
        chk("t7_ss_never", 32'(ss_seen), 32'd0);
        chk("t7_edges", edges - e0, 32'd2);
        chk("t7_latency", lat, 32'd5);
        chk("t7_rx_data", rxd, 32'h1);
        repeat (3) @(negedge pclk);
        chk("t7_rx_valid_once", rxv_cnt - r0, 32'd1);

        // Maximum divider: H = 256
        set_cfg(32'h1, 6'd1, 8'd255, 1'b0, 1'b0, 1'b0, 4'b1000);
        @(negedge pclk);
        start_req(1'b0);
        wait_done();
        chk("t8_latency", lat, 32'd1025);
        chk("t8_rx_data", rxd, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
